// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus four-state debounce FSM for one raw pad input.
// Optional rising-edge counter is built only when DEBOUNCE_EDGE_COUNT_EN is defined.
module input_debouncer #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din_raw,
    output logic       dout,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] edge_count,
    output logic [1:0] state_dbg
);

    // Handshake: none; din_raw is level-sampled every clock, outputs are registered levels/pulses.
    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_EDGE_COUNT_EN
    logic [7:0] edge_cnt_q;
    assign edge_count = edge_cnt_q;
`else
    assign edge_count = 8'h00;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
`ifdef DEBOUNCE_EDGE_COUNT_EN
            edge_cnt_q <= 8'h00;
`endif
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (en && s2) begin
                        state <= CHECK_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHECK_HIGH: begin
                    // Disable or a sample back at the old level aborts qualification.
                    if (!en || !s2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state      <= IDLE_HIGH;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        dout       <= 1'b1;
                        rise_pulse <= 1'b1;
`ifdef DEBOUNCE_EDGE_COUNT_EN
                        edge_cnt_q <= edge_cnt_q + 8'd1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (en && !s2) begin
                        state <= CHECK_LOW;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHECK_LOW: begin
                    if (!en || s2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state      <= IDLE_LOW;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        dout       <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: run-length reference model compared every cycle,
// plus directed edge-numbered scenarios with literal expectations.
module tb_input_debouncer;

    localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_COUNT_EN
    localparam logic EC_EN = 1'b1;
`else
    localparam logic EC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       din_raw = 1'b0;
    logic       dout;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] edge_count;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din_raw(din_raw),
        .dout(dout), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .busy(busy), .edge_count(edge_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: a level change is accepted once the synchronised input
    // has differed from the output for STABLE+1 consecutive enabled samples.
    logic [1:0] m_pipe = 2'b00;
    int         m_run = 0;
    logic       m_dout = 1'b0;
    logic       m_rise = 1'b0;
    logic       m_fall = 1'b0;
    logic [7:0] m_ecnt = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe = 2'b00; m_run = 0; m_dout = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_ecnt = 8'h00;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en && (m_pipe[1] != m_dout)) begin
                m_run = m_run + 1;
                if (m_run == STABLE + 1) begin
                    m_dout = ~m_dout;
                    m_run = 0;
                    if (m_dout) begin
                        m_rise = 1'b1;
                        if (EC_EN) m_ecnt = m_ecnt + 8'd1;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_pipe = {m_pipe[0], din_raw};
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_dout", {7'd0, dout}, {7'd0, m_dout});
            check("m_rise", {7'd0, rise_pulse}, {7'd0, m_rise});
            check("m_fall", {7'd0, fall_pulse}, {7'd0, m_fall});
            check("m_busy", {7'd0, busy}, {7'd0, m_run > 0});
            check("m_ecnt", edge_count, m_ecnt);
        end
    end

    task automatic edge_n();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic v, input int n);
        @(negedge clk);
        din_raw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_busy;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_dout", {7'd0, dout}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_ecnt", edge_count, 8'd0);
        settle(1'b0, 5);

        // Clean rise: edges numbered from the first edge that samples the new value.
        din_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            edge_n();
            check($sformatf("rise_busy_e%0d", k), {7'd0, busy}, {7'd0, (k >= 3 && k <= 6)});
            check($sformatf("rise_dout_e%0d", k), {7'd0, dout}, {7'd0, (k >= 7)});
            check($sformatf("rise_pulse_e%0d", k), {7'd0, rise_pulse}, {7'd0, (k == 7)});
        end
        check("rise_ecnt", edge_count, EC_EN ? 8'd1 : 8'd0);

        // Clean fall.
        @(negedge clk);
        din_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            edge_n();
            check($sformatf("fall_busy_e%0d", k), {7'd0, busy}, {7'd0, (k >= 3 && k <= 6)});
            check($sformatf("fall_dout_e%0d", k), {7'd0, dout}, {7'd0, (k < 7)});
            check($sformatf("fall_pulse_e%0d", k), {7'd0, fall_pulse}, {7'd0, (k == 7)});
        end
        check("fall_ecnt", edge_count, EC_EN ? 8'd1 : 8'd0);

        // Glitch: high for three cycles only.
        settle(1'b0, 3);
        din_raw = 1'b1;
        repeat (3) @(negedge clk);
        din_raw = 1'b0;
        saw_busy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            edge_n();
            saw_busy = saw_busy | busy;
            check($sformatf("glitch_dout_e%0d", k), {7'd0, dout}, 8'd0);
            check($sformatf("glitch_rise_e%0d", k), {7'd0, rise_pulse}, 8'd0);
        end
        check("glitch_saw_busy", {7'd0, saw_busy}, 8'd1);
        check("glitch_ecnt", edge_count, EC_EN ? 8'd1 : 8'd0);

        // Reset mid-CHECK_HIGH with the counter at 2, then requalify.
        settle(1'b0, 4);
        din_raw = 1'b1;
        for (int k = 1; k <= 5; k++) edge_n();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_dout", {7'd0, dout}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_rise", {7'd0, rise_pulse}, 8'd0);
        check("rst_fall", {7'd0, fall_pulse}, 8'd0);
        check("rst_ecnt", edge_count, 8'd0);
        check("rst_state", {6'd0, state_dbg}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            edge_n();
            check($sformatf("rrise_busy_e%0d", k), {7'd0, busy}, {7'd0, (k >= 3 && k <= 6)});
            check($sformatf("rrise_pulse_e%0d", k), {7'd0, rise_pulse}, {7'd0, (k == 7)});
        end

        // Enable dropped during CHECK_HIGH, then full requalification.
        settle(1'b0, 12);
        din_raw = 1'b1;
        for (int k = 1; k <= 4; k++) edge_n();
        check("en_busy_before", {7'd0, busy}, 8'd1);
        @(negedge clk);
        en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            edge_n();
            check($sformatf("endis_busy_%0d", k), {7'd0, busy}, 8'd0);
            check($sformatf("endis_dout_%0d", k), {7'd0, dout}, 8'd0);
        end
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge_n();
            check($sformatf("enre_busy_e%0d", k), {7'd0, busy}, {7'd0, (k >= 1 && k <= 4)});
            check($sformatf("enre_rise_e%0d", k), {7'd0, rise_pulse}, {7'd0, (k == 5)});
        end

        // Randomised segments with occasional enable drops and resets.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            @(negedge clk);
            din_raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                en = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 60) == 0) begin
                    #2 rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        en = 1'b1;

        // 256 rise/fall cycles: the edge counter wraps back to zero.
        pulse_reset();
        settle(1'b0, 4);
        for (int i = 0; i < 256; i++) begin
            din_raw = 1'b1;
            repeat (9) @(negedge clk);
            if (i == 0) check("wrap_first", edge_count, EC_EN ? 8'd1 : 8'd0);
            if (i == 255) check("wrap_last", edge_count, 8'd0);
            din_raw = 1'b0;
            repeat (9) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
